// File: rtl/spi_pkg.sv
// Shared encodings and width helpers for the slow-control SPI master.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} spi_state_t;

  localparam int CS_COMP_DAC = 0;
  localparam int CS_CAL_DAC  = 1;
  localparam int CS_CAL_ADC  = 2;

  function automatic int cs_w(input int ncs);
    return (ncs <= 2) ? 1 : $clog2(ncs);
  endfunction

  function automatic int nb_w(input int maxbits);
    return $clog2(maxbits + 1);
  endfunction

  function automatic int div_w(input int clkdiv);
    return (clkdiv <= 2) ? 1 : $clog2(clkdiv);
  endfunction

endpackage

// File: rtl/spi_phase_ctr.sv
// Phase timer: load at phase entry, last is high on the final cycle of a CLKDIV-cycle phase.
module spi_phase_ctr
  import spi_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam int W = div_w(CLKDIV);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= W'(CLKDIV - 1);
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/spi_cs_master.sv
// Mode-0 SPI master with per-device active-low chip selects and parallel RX capture.
module spi_cs_master
  import spi_pkg::*;
#(
  parameter int NCS     = 3,
  parameter int MAXBITS = 32,
  parameter int CLKDIV  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [cs_w(NCS)-1:0]     CS_SEL,
  input  logic [nb_w(MAXBITS)-1:0] NBITS,
  input  logic [MAXBITS-1:0]       TX_DATA,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic [MAXBITS-1:0]       RX_DATA,
  output logic                     SPI_CK,
  output logic                     SPI_DAT,
  output logic [NCS-1:0]           CS_B,
  input  logic                     SPI_RTN
);

  localparam int NBW = nb_w(MAXBITS);

  spi_state_t         state;
  logic [NBW-1:0]     bits_left;
  logic [MAXBITS-1:0] tx_sh, rx_sh, tx_al;
  logic               rtn_q, ph_last, ph_load, req_ok;

  assign req_ok  = (32'(CS_SEL) < NCS) && (NBITS != '0) && (32'(NBITS) <= MAXBITS);
  assign ph_load = (state == IDLE) ? (START && req_ok) : ph_last;
  // Left-align the request so the first bit is always the MSB of the shifter.
  assign tx_al   = TX_DATA << (MAXBITS - 32'(NBITS));

  spi_phase_ctr #(.CLKDIV(CLKDIV)) u_phase (
    .clk (CLK),
    .rst (RST),
    .load(ph_load),
    .last(ph_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      bits_left <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rtn_q     <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      RX_DATA   <= '0;
      SPI_CK    <= 1'b0;
      SPI_DAT   <= 1'b0;
      CS_B      <= '1;
    end else begin
      rtn_q <= SPI_RTN;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      case (state)
        IDLE: if (START) begin
          if (req_ok) begin
            state     <= SETUP;
            CS_B      <= ~(NCS'(1) << CS_SEL);
            tx_sh     <= tx_al;
            SPI_DAT   <= tx_al[MAXBITS-1];
            bits_left <= NBITS;
            rx_sh     <= '0;
            BUSY      <= 1'b1;
          end else begin
            ERR <= 1'b1;
          end
        end
        SETUP: if (ph_last) begin
          state  <= HIGH;
          SPI_CK <= 1'b1;
        end
        HIGH: if (ph_last) begin
          state     <= LOW;
          SPI_CK    <= 1'b0;
          rx_sh     <= {rx_sh[MAXBITS-2:0], rtn_q};
          bits_left <= bits_left - 1'b1;
          // After the final bit the data line holds until the gap.
          if (bits_left != NBW'(1)) begin
            tx_sh   <= tx_sh << 1;
            SPI_DAT <= tx_sh[MAXBITS-2];
          end
        end
        LOW: if (ph_last) begin
          if (bits_left != '0) begin
            state  <= HIGH;
            SPI_CK <= 1'b1;
          end else begin
            state   <= GAP;
            CS_B    <= '1;
            SPI_DAT <= 1'b0;
          end
        end
        GAP: if (ph_last) begin
          state   <= IDLE;
          RX_DATA <= rx_sh;
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cs_master.sv
// Randomized bench for spi_cs_master against a cycle-timing reference model.
module tb_spi_cs_master;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        START = 1'b0, START1 = 1'b0;
  logic [1:0]  CS_SEL = '0;
  logic [5:0]  NBITS = '0;
  logic [31:0] TX_DATA = '0;
  logic        BUSY, DONE, ERR, SPI_CK, SPI_DAT, SPI_RTN;
  logic [31:0] RX_DATA;
  logic [2:0]  CS_B;
  logic        BUSY1, DONE1, ERR1, SPI_CK1, SPI_DAT1, SPI_RTN1;
  logic [31:0] RX_DATA1;
  logic [2:0]  CS_B1;
  logic        lb = 1'b1, rtn_drv = 1'b0;

  int checks = 0, errors = 0;
  logic [31:0] last_rx = '0;

  assign SPI_RTN  = lb ? SPI_DAT : rtn_drv;
  assign SPI_RTN1 = SPI_DAT1;

  always #5 CLK = ~CLK;

  spi_cs_master #(.NCS(3), .MAXBITS(32), .CLKDIV(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CS_SEL(CS_SEL), .NBITS(NBITS), .TX_DATA(TX_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RX_DATA(RX_DATA), .SPI_CK(SPI_CK),
    .SPI_DAT(SPI_DAT), .CS_B(CS_B), .SPI_RTN(SPI_RTN));

  spi_cs_master #(.NCS(3), .MAXBITS(32), .CLKDIV(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START1), .CS_SEL(CS_SEL), .NBITS(NBITS), .TX_DATA(TX_DATA),
    .BUSY(BUSY1), .DONE(DONE1), .ERR(ERR1), .RX_DATA(RX_DATA1), .SPI_CK(SPI_CK1),
    .SPI_DAT(SPI_DAT1), .CS_B(CS_B1), .SPI_RTN(SPI_RTN1));

  // Reference model: cycle t counts clock edges after the one that accepted START.
  function automatic bit m_busy(int d, int n, int t); return t >= 1 && t <= d*(2*n+2); endfunction
  function automatic bit m_cs(int d, int n, int t);   return t >= 1 && t <= d*(2*n+1); endfunction
  function automatic bit m_ck(int d, int n, int t);
    int p = (t - 1) / d;
    return t >= 1 && (p % 2 == 1) && p < 2*n;
  endfunction
  function automatic int m_idx(int d, int n, int t);
    int b = ((t - 1) / d) / 2;
    if (b > n - 1) b = n - 1;
    return n - 1 - b;
  endfunction

  task automatic run_xfer(input int cs, input int n, input logic [31:0] tx, input bit lpb,
                          input logic [31:0] rpat, input bit started, input int mid_t,
                          input bit nxt_en, input int nxt_cs, input int nxt_n, input logic [31:0] nxt_tx);
    int d = 2;
    int last = d*(2*n+2) + 1;
    int rises = 0;
    logic prev_ck = 1'b0;
    logic [31:0] mask, exp_rx, e_rx;
    logic [2:0] e_cs;
    logic e_dat;
    mask   = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    exp_rx = (lpb ? tx : rpat) & mask;
    lb = lpb;
    if (!started) begin
      CS_SEL = 2'(cs); NBITS = 6'(n); TX_DATA = tx; START = 1'b1;
    end
    @(posedge CLK); #1 START = 1'b0;
    for (int t = 1; t <= last; t++) begin
      if (t > 1) begin @(posedge CLK); #1; end
      rtn_drv = rpat[m_idx(d, n, t)];
      if (t == mid_t) begin CS_SEL = 2'((cs + 1) % 3); NBITS = 6'd3; START = 1'b1; end
      if (t == mid_t + 1) START = 1'b0;
      @(negedge CLK);
      e_cs  = m_cs(d, n, t) ? ~(3'b001 << cs) : 3'b111;
      e_dat = m_cs(d, n, t) ? tx[m_idx(d, n, t)] : 1'b0;
      e_rx  = (t == last) ? exp_rx : last_rx;
      checks += 7;
      if (BUSY !== m_busy(d, n, t)) begin errors++; $display("FAIL busy t=%0d got %b exp %b", t, BUSY, m_busy(d, n, t)); end
      if (CS_B !== e_cs) begin errors++; $display("FAIL cs_b t=%0d got %b exp %b", t, CS_B, e_cs); end
      if (SPI_CK !== m_ck(d, n, t)) begin errors++; $display("FAIL spi_ck t=%0d got %b exp %b", t, SPI_CK, m_ck(d, n, t)); end
      if (SPI_DAT !== e_dat) begin errors++; $display("FAIL spi_dat t=%0d got %b exp %b", t, SPI_DAT, e_dat); end
      if (DONE !== (t == last)) begin errors++; $display("FAIL done t=%0d got %b exp %b", t, DONE, t == last); end
      if (ERR !== 1'b0) begin errors++; $display("FAIL err t=%0d got %b exp 0", t, ERR); end
      if (RX_DATA !== e_rx) begin errors++; $display("FAIL rx_data t=%0d got %h exp %h", t, RX_DATA, e_rx); end
      if (SPI_CK && !prev_ck) rises++;
      prev_ck = SPI_CK;
    end
    checks++;
    if (rises != n) begin errors++; $display("FAIL ck_pulses got %0d exp %0d", rises, n); end
    last_rx = exp_rx;
    if (nxt_en) begin
      CS_SEL = 2'(nxt_cs); NBITS = 6'(nxt_n); TX_DATA = nxt_tx; START = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks += 7;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", BUSY); end
    if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", DONE); end
    if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", ERR); end
    if (RX_DATA !== 32'h0) begin errors++; $display("FAIL rst_rx got %h exp 0", RX_DATA); end
    if (SPI_CK !== 1'b0) begin errors++; $display("FAIL rst_ck got %b exp 0", SPI_CK); end
    if (SPI_DAT !== 1'b0) begin errors++; $display("FAIL rst_dat got %b exp 0", SPI_DAT); end
    if (CS_B !== 3'b111) begin errors++; $display("FAIL rst_cs got %b exp 111", CS_B); end
    RST = 1'b0;
    last_rx = '0;
  endtask

  task automatic test_loopback();
    run_xfer(1, 8, 32'h0000_00A5, 1'b1, 32'h0, 1'b0, 0, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic test_full_width();
    run_xfer(0, 32, 32'h8000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_xfer(int'($urandom_range(0, 2)), int'($urandom_range(1, 32)), $urandom, 1'b0,
               $urandom, 1'b0, 0, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic test_invalid();
    int bad_cs [3] = '{3, 1, 2};
    int bad_n  [3] = '{8, 0, 33};
    for (int i = 0; i < 3; i++) begin
      #1 CS_SEL = 2'(bad_cs[i]); NBITS = 6'(bad_n[i]); TX_DATA = $urandom; START = 1'b1;
      @(posedge CLK); #1 START = 1'b0;
      @(negedge CLK);
      checks += 5;
      if (ERR !== 1'b1) begin errors++; $display("FAIL inv_err case %0d got %b exp 1", i, ERR); end
      if (BUSY !== 1'b0) begin errors++; $display("FAIL inv_busy case %0d got %b exp 0", i, BUSY); end
      if (CS_B !== 3'b111) begin errors++; $display("FAIL inv_cs case %0d got %b exp 111", i, CS_B); end
      if (SPI_CK !== 1'b0) begin errors++; $display("FAIL inv_ck case %0d got %b exp 0", i, SPI_CK); end
      if (RX_DATA !== last_rx) begin errors++; $display("FAIL inv_rx case %0d got %h exp %h", i, RX_DATA, last_rx); end
      @(negedge CLK);
      checks += 2;
      if (ERR !== 1'b0) begin errors++; $display("FAIL inv_err_pulse case %0d got %b exp 0", i, ERR); end
      if (BUSY !== 1'b0) begin errors++; $display("FAIL inv_busy2 case %0d got %b exp 0", i, BUSY); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] t2 = $urandom;
    run_xfer(2, 6, $urandom, 1'b1, 32'h0, 1'b0, 9, 1'b1, 0, 12, t2);
    run_xfer(0, 12, t2, 1'b0, $urandom, 1'b1, 0, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    CS_SEL = 2'd2; NBITS = 6'd16; TX_DATA = $urandom; START = 1'b1; lb = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (CS_B !== 3'b011) begin errors++; $display("FAIL rmid_active got %b exp 011", CS_B); end
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    checks += 5;
    if (CS_B !== 3'b111) begin errors++; $display("FAIL rmid_cs got %b exp 111", CS_B); end
    if (SPI_CK !== 1'b0) begin errors++; $display("FAIL rmid_ck got %b exp 0", SPI_CK); end
    if (BUSY !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", BUSY); end
    if (RX_DATA !== 32'h0) begin errors++; $display("FAIL rmid_rx got %h exp 0", RX_DATA); end
    if (SPI_DAT !== 1'b0) begin errors++; $display("FAIL rmid_dat got %b exp 0", SPI_DAT); end
    RST = 1'b0;
    last_rx = '0;
    for (int t = 0; t < 80; t++) begin
      @(negedge CLK);
      checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
        errors++; $display("FAIL rmid_after t=%0d done %b busy %b exp 0 0", t, DONE, BUSY);
      end
    end
  endtask

  task automatic test_div1_min();
    logic [31:0] tx = $urandom;
    CS_SEL = 2'd0; NBITS = 6'd1; TX_DATA = tx; START1 = 1'b1;
    @(posedge CLK); #1 START1 = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      if (t > 1) @(posedge CLK);
      @(negedge CLK);
      checks += 5;
      if (SPI_CK1 !== m_ck(1, 1, t)) begin errors++; $display("FAIL d1_ck t=%0d got %b exp %b", t, SPI_CK1, m_ck(1, 1, t)); end
      if (BUSY1 !== m_busy(1, 1, t)) begin errors++; $display("FAIL d1_busy t=%0d got %b exp %b", t, BUSY1, m_busy(1, 1, t)); end
      if (CS_B1 !== (m_cs(1, 1, t) ? 3'b110 : 3'b111)) begin errors++; $display("FAIL d1_cs t=%0d got %b", t, CS_B1); end
      if (DONE1 !== (t == 5)) begin errors++; $display("FAIL d1_done t=%0d got %b exp %b", t, DONE1, t == 5); end
      if (t == 5 && RX_DATA1 !== {31'h0, tx[0]}) begin errors++; $display("FAIL d1_rx got %h exp %h", RX_DATA1, {31'h0, tx[0]}); end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_full_width();
    test_invalid();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_div1_min();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cs_master.md
# spi_cs_master

Parametrised SPI master for the DCFEB slow-control SPI bus, replacing per-device chip-select decoding and serial clock generation. It accepts one transfer request at a time (chip select, bit count, transmit word), generates SPI clock, data and an active-low chip select for one of NCS devices (comparator DAC, calibration DAC, calibration ADC, ...), and captures the return line into a parallel word. The pad buffers stay in the existing I/O wrapper; this block drives and receives the fabric side.

## Interface
Parameters:
- NCS, 3, number of chip selects (bit 0 comp DAC, 1 cal DAC, 2 cal ADC)
- MAXBITS, 32, maximum transfer length in bits
- CLKDIV, 4, SPI_CK half-period in CLK cycles (≥1)

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- START  in  1  transfer request, sampled only while BUSY=0
- CS_SEL  in  max(1,$clog2(NCS))  chip-select index
- NBITS  in  $clog2(MAXBITS+1)  transfer length
- TX_DATA  in  MAXBITS  transmit word, right-justified; TX_DATA[NBITS-1] sent first
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle pulse, RX_DATA valid
- ERR  out  1  one-cycle pulse, request rejected
- RX_DATA  out  MAXBITS  received word, right-justified, upper bits zero
- SPI_CK  out  1  serial clock, idle low
- SPI_DAT  out  1  serial data out
- CS_B  out  NCS  active-low chip selects
- SPI_RTN  in  1  serial return data

## Operation
- Mode 0 only: SPI_CK idles low; SPI_DAT changes on falling edges (first bit at CS assertion); SPI_RTN sampled at the last CLK cycle of each SPI_CK high phase.
- SPI_RTN passes through one input register; the sample uses the registered value.
- All outputs registered. Reset values: SPI_CK=0, SPI_DAT=0, CS_B=all 1, BUSY=0, DONE=0, ERR=0, RX_DATA=0.
- States: IDLE, SETUP, HIGH, LOW, GAP.
- IDLE: on START with CS_SEL<NCS and 1≤NBITS≤MAXBITS, latch TX_DATA/NBITS/CS_SEL, go SETUP; CS_B[CS_SEL]=0, SPI_DAT=TX_DATA[NBITS-1], BUSY=1, RX shift register cleared.
- Invalid request (CS_SEL≥NCS, NBITS=0, NBITS>MAXBITS): ERR pulse next cycle, stay IDLE, no pin activity, RX_DATA unchanged.
- SETUP: CLKDIV cycles, SPI_CK=0 → HIGH.
- HIGH: CLKDIV cycles, SPI_CK=1; last cycle shifts sample into RX LSB, decrements bit counter → LOW.
- LOW: CLKDIV cycles, SPI_CK=0; first cycle presents next bit on SPI_DAT (except after last bit, where SPI_DAT holds). End: bits remain → HIGH, else → GAP.
- GAP: CLKDIV cycles, CS_B all 1, SPI_CK=0, SPI_DAT=0 → IDLE; RX_DATA updated, DONE=1, BUSY=0 on IDLE entry.
- START while BUSY=1 ignored (no ERR, no queueing).
- START on DONE cycle accepted (back-to-back; GAP guarantees CS-high time).
- RST mid-transfer: next cycle all outputs at reset values, no DONE, request lost.
- Exactly one CS_B bit low at any time; never glitches between selects.

## Timing
- START sampled at cycle 0; CS_B low, BUSY high from cycle 1.
- First SPI_CK rise at cycle CLKDIV+1; bit k (0-based) rises at CLKDIV*(2k+1)+1.
- BUSY high for CLKDIV*(2*NBITS+2) cycles; DONE at cycle CLKDIV*(2*NBITS+2)+1.
- Example CLKDIV=2, NBITS=8: BUSY cycles 1–36, CS_B low 1–34, DONE at 37.
- SPI_RTN to sample latency: one register stage; slave data must be stable ≥2 CLK before end of high phase.

## Structure
- Package spi_pkg: state encoding constants (IDLE, SETUP, HIGH, LOW, GAP), chip-select index constants (CS_COMP_DAC=0, CS_CAL_DAC=1, CS_CAL_ADC=2), width helper functions.
- One sub-module: spi_phase_ctr — loadable down-counter generating the end-of-phase strobe every CLKDIV cycles; main FSM, bit counter and shift registers in spi_cs_master.

## Test plan
- CLKDIV=2, CS_SEL=1, NBITS=8, TX_DATA=8'hA5, SPI_RTN looped from SPI_DAT → CS_B=3'b101 cycles 1–34, SPI_DAT sequence 1,0,1,0,0,1,0,1, DONE at cycle 37, RX_DATA=32'h000000A5.
- NBITS=32, TX_DATA=32'h8000_0001, SPI_RTN tied 1 → 32 SPI_CK pulses, RX_DATA=32'hFFFF_FFFF, DONE at CLKDIV*66+1.
- CS_SEL=3 (NCS=3), then NBITS=0, then NBITS=33 → ERR pulse each, BUSY stays 0, CS_B stays 3'b111, RX_DATA unchanged.
- START re-asserted mid-transfer and on DONE cycle → mid-transfer ignored; DONE-cycle request starts immediately, CS_B high ≥CLKDIV cycles between transfers.
- RST asserted at cycle 10 of a 16-bit transfer → cycle 11: CS_B=all 1, SPI_CK=0, BUSY=0, RX_DATA=0; no DONE afterwards.
- CLKDIV=1, NBITS=1 → SPI_CK high exactly 1 cycle, DONE at cycle 5.
